// File: rtl/serializer_gen.sv
`default_nettype none
// ============================================================================
// serializer_gen
// Parallel word to bit-serial valid/ready stream, LSB- or MSB-first.
// Revision: 1.0
// ============================================================================
module serializer_gen #(
  parameter int CONFIG = 0,
  parameter int WIDTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [CNT_W-1:0] cnt;
  logic             head_bit;
  logic             last_beat;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // The output end of sr and the shift direction depend on bit order.
  generate
    if (CONFIG == 0) begin : g_lsb_first
      assign head_bit   = sr[0];
      assign sr_shifted = sr >> 1;
    end else begin : g_msb_first
      assign head_bit   = sr[WIDTH-1];
      assign sr_shifted = sr << 1;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_xfer) state_next = SHIFT;
      SHIFT:   if (out_xfer && last_beat && !in_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready is the only output allowed to depend combinationally on inputs.
  always_comb begin
    last_beat = (cnt == LAST_CNT);
    out_valid = (state == SHIFT);
    out_last  = out_valid && last_beat;
    out_bit   = out_valid && head_bit;
    in_ready  = !reset && ((state == IDLE) || (out_last && out_ready));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (in_xfer) begin
      sr  <= in_data;
      cnt <= '0;
    end else if (out_xfer) begin
      if (last_beat) begin
        sr  <= '0;
        cnt <= '0;
      end else begin
        sr  <= sr_shifted;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializer_gen.sv
`default_nettype none
// ============================================================================
// tb_serializer_gen
// Scoreboard bench over four serializer_gen configurations.
// Revision: 1.0
// ============================================================================
module tb_serializer_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // a: LSB W4, b: MSB W4, c: LSB W8, d: LSB W1
  logic rst_a, iv_a, ir_a, ov_a, ordy_a, ob_a, ol_a;
  logic rst_b, iv_b, ir_b, ov_b, ordy_b, ob_b, ol_b;
  logic rst_c, iv_c, ir_c, ov_c, ordy_c, ob_c, ol_c;
  logic rst_d, iv_d, ir_d, ov_d, ordy_d, ob_d, ol_d;
  logic [3:0] din_a, din_b;
  logic [7:0] din_c;
  logic [0:0] din_d;

  bit [1:0] qa[$];
  bit [1:0] qb[$];
  bit [1:0] qc[$];
  bit [1:0] qd[$];

  serializer_gen #(.CONFIG(0), .WIDTH(4)) u_a (
    .clock(clock), .reset(rst_a), .in_valid(iv_a), .in_ready(ir_a), .in_data(din_a),
    .out_valid(ov_a), .out_ready(ordy_a), .out_bit(ob_a), .out_last(ol_a));
  serializer_gen #(.CONFIG(1), .WIDTH(4)) u_b (
    .clock(clock), .reset(rst_b), .in_valid(iv_b), .in_ready(ir_b), .in_data(din_b),
    .out_valid(ov_b), .out_ready(ordy_b), .out_bit(ob_b), .out_last(ol_b));
  serializer_gen #(.CONFIG(0), .WIDTH(8)) u_c (
    .clock(clock), .reset(rst_c), .in_valid(iv_c), .in_ready(ir_c), .in_data(din_c),
    .out_valid(ov_c), .out_ready(ordy_c), .out_bit(ob_c), .out_last(ol_c));
  serializer_gen #(.CONFIG(0), .WIDTH(1)) u_d (
    .clock(clock), .reset(rst_d), .in_valid(iv_d), .in_ready(ir_d), .in_data(din_d),
    .out_valid(ov_d), .out_ready(ordy_d), .out_bit(ob_d), .out_last(ol_d));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitors: pop one expected {bit,last} per observed output transfer.
  always @(negedge clock) begin
    bit [1:0] e;
    if (!rst_a && ov_a && ordy_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got bit %0b with empty queue", ob_a);
      end else begin
        e = qa.pop_front();
        check("a_bit", 32'(ob_a), 32'(e[1]));
        check("a_last", 32'(ol_a), 32'(e[0]));
      end
    end
  end

  always @(negedge clock) begin
    bit [1:0] e;
    if (!rst_b && ov_b && ordy_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bit %0b with empty queue", ob_b);
      end else begin
        e = qb.pop_front();
        check("b_bit", 32'(ob_b), 32'(e[1]));
        check("b_last", 32'(ol_b), 32'(e[0]));
      end
    end
  end

  always @(negedge clock) begin
    bit [1:0] e;
    if (!rst_c && ov_c && ordy_c) begin
      if (qc.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_unexpected: got bit %0b with empty queue", ob_c);
      end else begin
        e = qc.pop_front();
        check("c_bit", 32'(ob_c), 32'(e[1]));
        check("c_last", 32'(ol_c), 32'(e[0]));
      end
    end
  end

  always @(negedge clock) begin
    bit [1:0] e;
    if (!rst_d && ov_d && ordy_d) begin
      if (qd.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_unexpected: got bit %0b with empty queue", ob_d);
      end else begin
        e = qd.pop_front();
        check("d_bit", 32'(ob_d), 32'(e[1]));
        check("d_last", 32'(ol_d), 32'(e[0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] wc;
    {rst_a, rst_b, rst_c, rst_d} = 4'hF;
    {iv_a, iv_b, iv_c, iv_d} = 4'h0;
    {ordy_a, ordy_b, ordy_c, ordy_d} = 4'hF;
    din_a = '0; din_b = '0; din_c = '0; din_d = '0;
    tick(); tick();
    check("rst_ov", 32'(ov_a), 0);
    check("rst_ir", 32'(ir_a), 0);
    {rst_a, rst_b, rst_c, rst_d} = 4'h0;
    #1;
    check("a_ready_after_reset", 32'(ir_a), 1);

    // LSB-first 1011 -> 1,1,0,1
    iv_a = 1; din_a = 4'b1011;
    qa.push_back(2'b10); qa.push_back(2'b10); qa.push_back(2'b00); qa.push_back(2'b11);
    tick(); iv_a = 0;
    repeat (4) tick();
    check("a_idle_after_word", 32'(ov_a), 0);

    // Reset held 3 cycles during a word
    ordy_a = 0; iv_a = 1; din_a = 4'b1111;
    tick(); iv_a = 0;
    check("a_busy_before_reset", 32'(ov_a), 1);
    rst_a = 1; #1;
    check("a_ir_in_reset_comb", 32'(ir_a), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_rst_ov", 32'(ov_a), 0);
      check("a_rst_ol", 32'(ol_a), 0);
      check("a_rst_ob", 32'(ob_a), 0);
      check("a_rst_ir", 32'(ir_a), 0);
    end
    rst_a = 0; #1;
    check("a_ir_first_after_reset", 32'(ir_a), 1);
    ordy_a = 1;

    // MSB-first 1011 then back-to-back 0110
    iv_b = 1; din_b = 4'b1011;
    qb.push_back(2'b10); qb.push_back(2'b00); qb.push_back(2'b10); qb.push_back(2'b11);
    tick(); iv_b = 0;
    for (int i = 0; i < 8; i++) begin
      check("b_no_gap", 32'(ov_b), 1);
      check("b_ready_last_only", 32'(ir_b), 32'((i % 4) == 3));
      if (i == 3) begin
        iv_b = 1; din_b = 4'b0110;
        qb.push_back(2'b00); qb.push_back(2'b10); qb.push_back(2'b10); qb.push_back(2'b01);
      end
      tick();
      if (i == 3) iv_b = 0;
    end
    check("b_idle_after", 32'(ov_b), 0);

    // W8 backpressure on A5, busy-time FF must be ignored
    wc = 8'hA5;
    iv_c = 1; din_c = wc;
    for (int k = 0; k < 8; k++) qc.push_back({wc[k], 1'(k == 7)});
    tick(); iv_c = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        ordy_c = 0; iv_c = 1; din_c = 8'hFF;
        for (int s = 0; s < 3; s++) begin
          check("c_busy_not_ready", 32'(ir_c), 0);
          tick();
          check("c_hold_bit", 32'(ob_c), 32'(wc[2]));
          check("c_hold_last", 32'(ol_c), 0);
          check("c_hold_valid", 32'(ov_c), 1);
        end
        iv_c = 0; ordy_c = 1;
      end
      tick();
    end
    check("c_idle_after", 32'(ov_c), 0);

    // W8 mid-word reset, then 3C serialises from bit 0
    ordy_c = 0; iv_c = 1; din_c = 8'hFF;
    tick(); iv_c = 0;
    tick();
    rst_c = 1;
    tick();
    rst_c = 0; ordy_c = 1;
    #1;
    check("c_ready_after_reset", 32'(ir_c), 1);
    wc = 8'h3C;
    iv_c = 1; din_c = wc;
    for (int k = 0; k < 8; k++) qc.push_back({wc[k], 1'(k == 7)});
    tick(); iv_c = 0;
    repeat (8) tick();
    check("c_idle_after_3c", 32'(ov_c), 0);

    // WIDTH=1: 1,0,1 back-to-back, last every beat
    iv_d = 1; din_d = 1'b1; qd.push_back(2'b11);
    tick();
    check("d_valid0", 32'(ov_d), 1);
    check("d_ready0", 32'(ir_d), 1);
    din_d = 1'b0; qd.push_back(2'b01);
    tick();
    check("d_valid1", 32'(ov_d), 1);
    check("d_ready1", 32'(ir_d), 1);
    din_d = 1'b1; qd.push_back(2'b11);
    tick(); iv_d = 0;
    check("d_valid2", 32'(ov_d), 1);
    check("d_last2", 32'(ol_d), 1);
    tick();
    check("d_idle_after", 32'(ov_d), 0);

    repeat (3) tick();
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    check("c_queue_drained", qc.size(), 0);
    check("d_queue_drained", qd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
